sim_run_monitor: RTL and testbench
==================================

Name: sim_run_monitor

Overview:
- Synthesizable run controller and verdict monitor for the sandhost simulation harness. Instantiated between the testbench clock/reset source and the DUT top.
- Sequences DUT reset, counts run cycles, and aggregates pass/fail flags from N checker channels with an enable mask.
- Detects timeout and hang (no progress heartbeat), then latches a single final verdict for the bench to read and call $finish on.

Parameters:
- CYC_W, 16, width of cycle counter and limit inputs.
- N_CHK, 4, number of checker channels.
- RESET_CYCLES, 5, cycles dut_reset stays high after reset release (min 1).
- IDLE_W, 8, width of the heartbeat watchdog counter.

Ports:
- clk  in  1  design clock.
- reset  in  1  synchronous, active-high reset.
- max_cycles  in  CYC_W  run-cycle limit; sampled when the block leaves RST_HOLD.
- idle_limit  in  IDLE_W  heartbeat timeout; 0 disables the watchdog; sampled with max_cycles.
- chk_en  in  N_CHK  channel enable mask; sampled with max_cycles.
- passed  in  N_CHK  per-channel pass flags.
- failed  in  N_CHK  per-channel fail flags.
- progress  in  1  DUT heartbeat pulse.
- dut_reset  out  1  reset driven to the DUT.
- cyc_cnt  out  CYC_W  RUN cycles elapsed.
- running  out  1  high in RUN.
- done  out  1  high in any DONE state; sticky until reset.
- verdict  out  2  0 = PASS, 1 = FAIL, 2 = TIMEOUT, 3 = HANG. Valid only while done is high.
- fail_idx  out  $clog2(N_CHK) (min 1)  lowest-index failing channel; valid when verdict = FAIL.

Behaviour:
- Reset values: dut_reset = 1, cyc_cnt = 0, running = 0, done = 0, verdict = 0, fail_idx = 0. Sticky pass vector and watchdog counter are cleared.
- States: RST_HOLD, RUN, DONE. verdict is a register, not separate states.
- RST_HOLD:
  - Hold counter counts from 0.
  - On the cycle the counter reaches RESET_CYCLES-1: go to RUN, latch the configuration inputs (max_cycles, idle_limit, chk_en), and drive dut_reset = 0 from the next cycle.
  - dut_reset is high for exactly RESET_CYCLES cycles after reset deasserts.
- RUN:
  - cyc_cnt increments each cycle, starting at 0 on the first RUN cycle.
  - Sticky pass vector: pass_seen[i] |= passed[i] & en[i].
  - Per-cycle evaluation, in priority order:
    1. Fail: any failed[i] & en[i] → DONE, verdict = FAIL, fail_idx = lowest such i.
    2. Pass: pass_seen including this cycle's passed covers en, and en != 0 → DONE, verdict = PASS.
    3. Hang: watchdog count == idle_limit-1, idle_limit != 0, and no progress this cycle → DONE, verdict = HANG.
    4. Timeout: cyc_cnt == max_cycles-1 → DONE, verdict = TIMEOUT.
  - Simultaneous pass and fail in the same cycle resolves to FAIL.
  - Pass on the final allowed cycle resolves to PASS, not TIMEOUT.
  - Watchdog counter clears on progress and otherwise increments, saturating.
  - max_cycles = 0: TIMEOUT on the first RUN cycle unless fail or pass resolves earlier in priority.
  - en == 0: pass is impossible; the run ends as TIMEOUT or HANG.
- DONE:
  - Absorbing state. cyc_cnt freezes. done = 1, running = 0. dut_reset stays 0, so waveforms after the verdict remain visible.
  - Inputs are ignored.
- Latency: the verdict is registered. done rises the cycle after the deciding input is sampled.
- Reset asserted mid-run or in DONE: next cycle returns to reset values and RST_HOLD, and the reset sequence restarts.
- Disabled channels (chk_en[i] = 0) are fully ignored, including X values: their flags are masked before any reduction.
- cyc_cnt cannot wrap, because the timeout fires at or before 2^CYC_W-1.

Decomposition:
- Package sim_run_pkg:
  - verdict_e enum (PASS, FAIL, TIMEOUT, HANG).
  - state_e enum (RST_HOLD, RUN, DONE).
  - Function lowest_set_idx(N_CHK).
- Sub-module sim_watchdog: saturating idle counter with clear, limit compare, and disable-on-zero. Reused by other harness variants.
- Top FSM, sticky pass vector and verdict register live in sim_run_monitor.

Test Plan:
- Configuration for scenarios 1–4: RESET_CYCLES = 5, chk_en = 4'b1111, max_cycles = 100, idle_limit = 0.
1. Reset sequencing: reset held 3 cycles then released → dut_reset high for exactly 5 cycles. running rises with cyc_cnt = 0.
2. Staggered pass: pass at RUN cycles 10, 20, 30, 40 on ch0..ch3 → done at the next cycle, verdict = PASS, cyc_cnt frozen at 40.
3. Simultaneous events: failed[2] and passed completing the vector at cycle 15 → verdict = FAIL, fail_idx = 2.
4. Timeout: no pass flags → done after cyc_cnt = 99, verdict = TIMEOUT. Passes completing exactly at cycle 99 in a rerun → verdict = PASS.
5. Hang and masking: idle_limit = 8, progress pulsed every 4 cycles until cycle 20 then stopped → HANG at cycle 28. chk_en = 4'b0011 with failed[3] = 1 throughout → no FAIL.
6. Mid-run reset: reset asserted at RUN cycle 50 → outputs return to reset values the next cycle. A full pass run then completes normally.

Source files
------------

// File: rtl/sim_run_pkg.sv
// Shared types and helpers for the simulation run monitor and its watchdog.
package sim_run_pkg;

  typedef enum logic [1:0] {
    V_PASS    = 2'd0,
    V_FAIL    = 2'd1,
    V_TIMEOUT = 2'd2,
    V_HANG    = 2'd3
  } verdict_e;

  typedef enum logic [1:0] {
    RST_HOLD = 2'd0,
    RUN      = 2'd1,
    DONE     = 2'd2
  } state_e;

  localparam int MAX_CHK = 32;

  // Priority encoder: index of the lowest set bit, 0 when none set.
  function automatic logic [4:0] lowest_set_idx(input logic [MAX_CHK-1:0] v);
    lowest_set_idx = '0;
    for (int i = MAX_CHK - 1; i >= 0; i--)
      if (v[i]) lowest_set_idx = 5'(i);
  endfunction

endpackage

// File: rtl/sim_watchdog.sv
// Saturating idle counter: cleared by progress or outside a run, flags a hang
// when the idle count reaches limit-1 with no progress; limit 0 disables it.
module sim_watchdog #(
  parameter int IDLE_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              progress,
  input  logic [IDLE_W-1:0] limit,
  output logic              hang
);

  logic [IDLE_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!run || progress)
      cnt_d = '0;
    else if (cnt_q != '1)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign hang = run && (limit != '0) && !progress && (cnt_q == limit - 1'b1);

endmodule

// File: rtl/sim_run_monitor.sv
// Run controller: sequences DUT reset, counts run cycles, aggregates checker
// flags and latches one final verdict (PASS/FAIL/TIMEOUT/HANG).
module sim_run_monitor
  import sim_run_pkg::*;
#(
  parameter int CYC_W        = 16,
  parameter int N_CHK        = 4,
  parameter int RESET_CYCLES = 5,
  parameter int IDLE_W       = 8,
  localparam int FI_W        = (N_CHK > 1) ? $clog2(N_CHK) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CYC_W-1:0]  max_cycles,
  input  logic [IDLE_W-1:0] idle_limit,
  input  logic [N_CHK-1:0]  chk_en,
  input  logic [N_CHK-1:0]  passed,
  input  logic [N_CHK-1:0]  failed,
  input  logic              progress,
  output logic              dut_reset,
  output logic [CYC_W-1:0]  cyc_cnt,
  output logic              running,
  output logic              done,
  output logic [1:0]        verdict,
  output logic [FI_W-1:0]   fail_idx
);

  localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);

  state_e            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [CYC_W-1:0]  max_q, max_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic [N_CHK-1:0]  en_q, en_d;
  logic [N_CHK-1:0]  pass_seen_q, pass_seen_d;
  logic [CYC_W-1:0]  cyc_cnt_q, cyc_cnt_d;
  logic              dut_reset_q, dut_reset_d;
  logic              running_q, running_d;
  logic              done_q, done_d;
  verdict_e          verdict_q, verdict_d;
  logic [FI_W-1:0]   fail_idx_q, fail_idx_d;

  logic [N_CHK-1:0]  pass_now, fail_v;
  logic              fail_hit, pass_hit, hang_hit, timeout_hit;

  sim_watchdog #(.IDLE_W(IDLE_W)) u_wdog (
    .clk      (clk),
    .reset    (reset),
    .run      (state_q == RUN),
    .progress (progress),
    .limit    (idle_q),
    .hang     (hang_hit)
  );

  // Disabled channels are masked before any reduction so X flags never leak.
  assign fail_v      = failed & en_q;
  assign pass_now    = pass_seen_q | (passed & en_q);
  assign fail_hit    = |fail_v;
  assign pass_hit    = (en_q != '0) && ((pass_now & en_q) == en_q);
  assign timeout_hit = (max_q == '0) || (cyc_cnt_q == max_q - 1'b1);

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    max_d       = max_q;
    idle_d      = idle_q;
    en_d        = en_q;
    pass_seen_d = pass_seen_q;
    cyc_cnt_d   = cyc_cnt_q;
    dut_reset_d = dut_reset_q;
    running_d   = running_q;
    done_d      = done_q;
    verdict_d   = verdict_q;
    fail_idx_d  = fail_idx_q;
    case (state_q)
      RST_HOLD: begin
        if (hold_q == HOLD_LAST) begin
          state_d     = RUN;
          dut_reset_d = 1'b0;
          running_d   = 1'b1;
          cyc_cnt_d   = '0;
          pass_seen_d = '0;
          max_d       = max_cycles;
          idle_d      = idle_limit;
          en_d        = chk_en;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      RUN: begin
        pass_seen_d = pass_now;
        if (fail_hit || pass_hit || hang_hit || timeout_hit) begin
          state_d   = DONE;
          running_d = 1'b0;
          done_d    = 1'b1;
          if (fail_hit) begin
            verdict_d  = V_FAIL;
            fail_idx_d = FI_W'(lowest_set_idx(MAX_CHK'(fail_v)));
          end else if (pass_hit) begin
            verdict_d = V_PASS;
          end else if (hang_hit) begin
            verdict_d = V_HANG;
          end else begin
            verdict_d = V_TIMEOUT;
          end
        end else begin
          cyc_cnt_d = cyc_cnt_q + 1'b1;
        end
      end
      default: ; // DONE absorbs until reset
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RST_HOLD;
      hold_q      <= '0;
      max_q       <= '0;
      idle_q      <= '0;
      en_q        <= '0;
      pass_seen_q <= '0;
      cyc_cnt_q   <= '0;
      dut_reset_q <= 1'b1;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
      verdict_q   <= V_PASS;
      fail_idx_q  <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      max_q       <= max_d;
      idle_q      <= idle_d;
      en_q        <= en_d;
      pass_seen_q <= pass_seen_d;
      cyc_cnt_q   <= cyc_cnt_d;
      dut_reset_q <= dut_reset_d;
      running_q   <= running_d;
      done_q      <= done_d;
      verdict_q   <= verdict_d;
      fail_idx_q  <= fail_idx_d;
    end
  end

  assign dut_reset = dut_reset_q;
  assign cyc_cnt   = cyc_cnt_q;
  assign running   = running_q;
  assign done      = done_q;
  assign verdict   = verdict_q;
  assign fail_idx  = fail_idx_q;

endmodule

// File: tb/tb_sim_run_monitor.sv
// Self-checking bench for sim_run_monitor: table of run scenarios with a
// scoreboard of expected verdicts, plus hand sequences for reset corners.
module tb_sim_run_monitor;

  localparam int V_PASS = 0, V_FAIL = 1, V_TIMEOUT = 2, V_HANG = 3;
  localparam int NONE = -1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] max_cycles = '0;
  logic [7:0]  idle_limit = '0;
  logic [3:0]  chk_en = '0;
  logic [3:0]  passed = '0;
  logic [3:0]  failed = '0;
  logic        progress = 1'b0;
  logic        dut_reset;
  logic [15:0] cyc_cnt;
  logic        running;
  logic        done;
  logic [1:0]  verdict;
  logic [1:0]  fail_idx;

  sim_run_monitor #(
    .CYC_W(16), .N_CHK(4), .RESET_CYCLES(5), .IDLE_W(8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .max_cycles (max_cycles),
    .idle_limit (idle_limit),
    .chk_en     (chk_en),
    .passed     (passed),
    .failed     (failed),
    .progress   (progress),
    .dut_reset  (dut_reset),
    .cyc_cnt    (cyc_cnt),
    .running    (running),
    .done       (done),
    .verdict    (verdict),
    .fail_idx   (fail_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    string           name;
    logic [3:0]      en;
    int              maxc;
    int              idle;
    int              prog_per;   // 0 = no progress pulses
    int              prog_stop;
    logic [3:0][7:0] pass_cyc;   // 255 = channel never passes
    logic [3:0]      fail_mask;
    int              fail_cyc;
    logic [3:0]      fail_always;
    int              exp_v;
    int              exp_cyc;
    int              exp_idx;
  } vec_t;

  typedef struct {
    int v;
    int cyc;
    int idx;
  } exp_t;

  vec_t vecs[12];
  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  function automatic vec_t mk(string nm, logic [3:0] en, int maxc, int idle,
                              int per, int stop, logic [31:0] pc,
                              logic [3:0] fm, int fc, logic [3:0] fa,
                              int ev, int ec, int ei);
    vec_t v;
    v.name = nm; v.en = en; v.maxc = maxc; v.idle = idle;
    v.prog_per = per; v.prog_stop = stop; v.pass_cyc = pc;
    v.fail_mask = fm; v.fail_cyc = fc; v.fail_always = fa;
    v.exp_v = ev; v.exp_cyc = ec; v.exp_idx = ei;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reset for 3 cycles, release, and measure the DUT reset hold window.
  task automatic start_run(input logic [3:0] en, input int maxc, input int idle);
    int n;
    reset = 1'b1; passed = '0; failed = '0; progress = 1'b0;
    chk_en = en; max_cycles = 16'(maxc); idle_limit = 8'(idle);
    repeat (3) @(negedge clk);
    chk("rst_dut_reset", int'(dut_reset), 1);
    chk("rst_running",   int'(running), 0);
    chk("rst_done",      int'(done), 0);
    chk("rst_cyc_cnt",   int'(cyc_cnt), 0);
    chk("rst_verdict",   int'(verdict), 0);
    chk("rst_fail_idx",  int'(fail_idx), 0);
    reset = 1'b0;
    n = 1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!dut_reset) break;
      n++;
    end
    chk("hold_len",  n, 5);
    chk("run_start", int'(running), 1);
    chk("run_cyc0",  int'(cyc_cnt), 0);
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    logic fin;
    exp_t pe;
    start_run(v.en, v.maxc, v.idle);
    pe.v = v.exp_v; pe.cyc = v.exp_cyc; pe.idx = v.exp_idx;
    exp_q.push_back(pe);
    fin = 1'b0;
    for (int k = 0; k < 250; k++) begin
      for (int i = 0; i < 4; i++) passed[i] = (int'(v.pass_cyc[i]) == k);
      failed   = v.fail_always | ((k == v.fail_cyc) ? v.fail_mask : 4'b0);
      progress = (v.prog_per != 0) && ((k % v.prog_per) == 0) && (k <= v.prog_stop);
      @(negedge clk);
      if (done) begin
        fin = 1'b1;
        break;
      end
    end
    e = exp_q.pop_front();
    if (!fin) begin
      checks++;
      failures++;
      $display("FAIL %s_done: got no done expected done within 250 cycles", v.name);
    end else begin
      chk({v.name, "_verdict"}, int'(verdict), e.v);
      chk({v.name, "_cyc"},     int'(cyc_cnt), e.cyc);
      chk({v.name, "_running"}, int'(running), 0);
      if (e.v == V_FAIL) chk({v.name, "_idx"}, int'(fail_idx), e.idx);
      // DONE must ignore every input and keep its outputs frozen.
      passed = '1; failed = '1; progress = 1'b1;
      repeat (3) @(negedge clk);
      chk({v.name, "_hold_done"},    int'(done), 1);
      chk({v.name, "_hold_cyc"},     int'(cyc_cnt), e.cyc);
      chk({v.name, "_hold_verdict"}, int'(verdict), e.v);
      chk({v.name, "_hold_dutrst"},  int'(dut_reset), 0);
    end
    passed = '0; failed = '0; progress = 1'b0;
  endtask

  initial begin
    vecs[0]  = mk("stagger",   4'hF, 100, 0, 0, 0, {8'd40, 8'd30, 8'd20, 8'd10},
                  4'h0, NONE, 4'h0, V_PASS, 40, 0);
    vecs[1]  = mk("pass_fail", 4'hF, 100, 0, 0, 0, {8'd15, 8'd12, 8'd8, 8'd5},
                  4'b0100, 15, 4'h0, V_FAIL, 15, 2);
    vecs[2]  = mk("timeout",   4'hF, 100, 0, 0, 0, {4{8'd255}},
                  4'h0, NONE, 4'h0, V_TIMEOUT, 99, 0);
    vecs[3]  = mk("pass_last", 4'hF, 100, 0, 0, 0, {8'd99, 8'd50, 8'd99, 8'd99},
                  4'h0, NONE, 4'h0, V_PASS, 99, 0);
    vecs[4]  = mk("hang_mask", 4'b0011, 100, 8, 4, 20, {4{8'd255}},
                  4'h0, NONE, 4'b1000, V_HANG, 28, 0);
    vecs[5]  = mk("max_zero",  4'hF, 0, 0, 0, 0, {4{8'd255}},
                  4'h0, NONE, 4'h0, V_TIMEOUT, 0, 0);
    vecs[6]  = mk("max0_pass", 4'hF, 0, 0, 0, 0, {4{8'd0}},
                  4'h0, NONE, 4'h0, V_PASS, 0, 0);
    vecs[7]  = mk("en_zero",   4'h0, 30, 0, 0, 0, {4{8'd2}},
                  4'h0, NONE, 4'hF, V_TIMEOUT, 29, 0);
    vecs[8]  = mk("low_idx",   4'hF, 100, 0, 0, 0, {4{8'd255}},
                  4'b1010, 7, 4'h0, V_FAIL, 7, 1);
    vecs[9]  = mk("part_en",   4'b0011, 100, 0, 0, 0, {8'd255, 8'd255, 8'd6, 8'd3},
                  4'h0, NONE, 4'b1100, V_PASS, 6, 0);
    vecs[10] = mk("hang_vs_to", 4'hF, 10, 10, 0, 0, {4{8'd255}},
                  4'h0, NONE, 4'h0, V_HANG, 9, 0);
    vecs[11] = mk("idle_one",  4'hF, 100, 1, 2, 100, {4{8'd255}},
                  4'h0, NONE, 4'h0, V_HANG, 1, 0);

    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // Mid-run reset at RUN cycle 50, then a full pass run.
    start_run(4'hF, 100, 0);
    repeat (50) @(negedge clk);
    chk("mid_cyc50", int'(cyc_cnt), 50);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_dut_reset", int'(dut_reset), 1);
    chk("mid_running",   int'(running), 0);
    chk("mid_cyc_cnt",   int'(cyc_cnt), 0);
    chk("mid_done",      int'(done), 0);
    run_vec(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
